// File: rtl/alu_pkg.sv
// Shared types and constants for the serial ALU link.
// Response receiver additions: frame/response FSM states, CRC3 helper.
package alu_pkg;

  localparam logic DATA_TYPE = 1'b0;
  localparam logic CMD_TYPE  = 1'b1;

  localparam logic [7:0] ERR_DATA_FRAME = 8'hC9;
  localparam logic [7:0] ERR_CRC_FRAME  = 8'hA5;
  localparam logic [7:0] ERR_OP_FRAME   = 8'h93;

  localparam int DATA_FRAMES_DEF = 4;
  localparam int IFG_TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    IDLE,
    TYPE,
    PAYLOAD,
    STOP,
    RESYNC
  } rx_state_t;

  typedef enum logic [1:0] {
    WAIT_DATA,
    WAIT_CTL,
    PUSH
  } rsp_state_t;

  // x^3+x+1, init 0, MSB first
  function automatic bit [2:0] calc_crc3(input bit [36:0] d);
    bit [2:0] c;
    bit       fb;
    c = '0;
    for (int i = 36; i >= 0; i--) begin
      fb = c[2] ^ d[i];
      c  = {c[1:0], 1'b0} ^ {1'b0, fb, fb};
    end
    return c;
  endfunction

endpackage

// File: rtl/alu_frame_rx.sv
// Bit-level deserialiser for 11-bit ALU frames (start, type, 8 data, stop).
// A start bit is only honoured after the line has been seen high since reset.
module alu_frame_rx
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sin,
  output logic       frame_vld,
  output logic       frame_type,
  output logic [7:0] frame_byte,
  output logic       frame_err,
  output logic       line_idle,
  output logic       frame_start
);

  rx_state_t  state, state_nxt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       type_q;
  logic       armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
      type_q  <= 1'b0;
      armed   <= 1'b0;
    end else begin
      armed <= armed | sin;
      if (state == TYPE) begin
        type_q  <= sin;
        bit_cnt <= '0;
      end
      if (state == PAYLOAD) begin
        shreg   <= {shreg[6:0], sin};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (armed && !sin) state_nxt = TYPE;
      TYPE:    state_nxt = PAYLOAD;
      PAYLOAD: if (bit_cnt == 3'd7) state_nxt = STOP;
      STOP:    state_nxt = sin ? IDLE : RESYNC;
      RESYNC:  if (sin) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    frame_vld   = (state == STOP) && sin;
    frame_err   = (state == STOP) && !sin;
    frame_type  = type_q;
    frame_byte  = shreg;
    line_idle   = (state == IDLE);
    frame_start = (state == IDLE) && armed && !sin;
  end

endmodule

// File: rtl/alu_result_rx.sv
// ALU response receiver: frames -> parallel response with valid/ready.
// Define ALU_RX_CRC_CHECK_EN to enable CRC3 and error-frame parity checks.
module alu_result_rx
  import alu_pkg::*;
#(
  parameter int DATA_FRAMES = DATA_FRAMES_DEF,
  parameter int IFG_TIMEOUT = IFG_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  input  logic        rsp_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_c,
  output logic [3:0]  rsp_flags,
  output logic [2:0]  rsp_err,
  output logic        crc_err,
  output logic        proto_err,
  output logic        overrun
);

  localparam int CW = $clog2(DATA_FRAMES + 1);
  localparam int IW = $clog2(IFG_TIMEOUT + 1);

  logic       frame_vld, frame_type, frame_err;
  logic       line_idle, frame_start;
  logic [7:0] frame_byte;

  alu_frame_rx u_frame (
    .clk         (clk),
    .rst         (rst),
    .sin         (sin),
    .frame_vld   (frame_vld),
    .frame_type  (frame_type),
    .frame_byte  (frame_byte),
    .frame_err   (frame_err),
    .line_idle   (line_idle),
    .frame_start (frame_start)
  );

  rsp_state_t    state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   acc;
  logic [IW-1:0] idle_cnt;
  logic          counting, timeout_hit;
  logic          take_data, take_ok, take_err, seq_err, push;
  logic          is_data, is_ok, is_err, err_known;
  logic          ok_bad, err_bad;
  logic [31:0]   pend_c;
  logic [3:0]    pend_flags;
  logic [2:0]    pend_err;
  logic          pend_crc;

  assign is_data   = (frame_type == DATA_TYPE);
  assign is_ok     = (frame_type == CMD_TYPE) && !frame_byte[7];
  assign is_err    = (frame_type == CMD_TYPE) && frame_byte[7];
  assign err_known = frame_byte inside
    {ERR_DATA_FRAME, ERR_CRC_FRAME, ERR_OP_FRAME};

`ifdef ALU_RX_CRC_CHECK_EN
  assign ok_bad  = calc_crc3({acc, 1'b0, frame_byte[6:3]})
                   != frame_byte[2:0];
  assign err_bad = ^frame_byte;
`else
  assign ok_bad  = 1'b0;
  assign err_bad = 1'b0;
`endif

  assign counting    = line_idle && (cnt != '0);
  assign timeout_hit = counting && (idle_cnt == IW'(IFG_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_DATA;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take_data = 1'b0;
    take_ok   = 1'b0;
    take_err  = 1'b0;
    seq_err   = 1'b0;
    unique case (state)
      WAIT_DATA, WAIT_CTL: begin
        if (frame_vld) begin
          unique case (1'b1)
            is_data: if (state == WAIT_DATA) take_data = 1'b1;
                     else seq_err = 1'b1;
            is_ok:   if (state == WAIT_CTL) take_ok = 1'b1;
                     else seq_err = 1'b1;
            is_err:  if (err_known) take_err = 1'b1;
                     else seq_err = 1'b1;
            default: ;
          endcase
        end
        if (take_ok || take_err)
          state_nxt = PUSH;
        else if (take_data && cnt == CW'(DATA_FRAMES - 1))
          state_nxt = WAIT_CTL;
        else if (seq_err || frame_err || timeout_hit)
          state_nxt = WAIT_DATA;
      end
      PUSH:    state_nxt = WAIT_DATA;
      default: state_nxt = WAIT_DATA;
    endcase
  end

  always_comb begin
    push = (state == PUSH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      acc        <= '0;
      pend_c     <= '0;
      pend_flags <= '0;
      pend_err   <= '0;
      pend_crc   <= 1'b0;
    end else if (take_data) begin
      acc <= {acc[23:0], frame_byte};
      cnt <= cnt + CW'(1);
    end else if (take_ok || take_err) begin
      cnt        <= '0;
      acc        <= '0;
      pend_c     <= take_ok ? acc : 32'h0;
      pend_flags <= take_ok ? frame_byte[6:3] : 4'h0;
      pend_err   <= take_ok ? 3'b000 :
                    {frame_byte[6] & frame_byte[3],
                     frame_byte[5] & frame_byte[2],
                     frame_byte[4] & frame_byte[1]};
      pend_crc   <= take_ok ? ok_bad : err_bad;
    end else if (seq_err || frame_err || timeout_hit) begin
      cnt <= '0;
      acc <= '0;
    end
  end

  // saturates after a timeout until the next start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      idle_cnt <= '0;
    else if (frame_start)
      idle_cnt <= '0;
    else if (counting && idle_cnt != IW'(IFG_TIMEOUT))
      idle_cnt <= idle_cnt + IW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) proto_err <= 1'b0;
    else     proto_err <= seq_err | frame_err | timeout_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_c     <= '0;
      rsp_flags <= '0;
      rsp_err   <= '0;
      crc_err   <= 1'b0;
      overrun   <= 1'b0;
    end else if (push) begin
      rsp_valid <= 1'b1;
      rsp_c     <= pend_c;
      rsp_flags <= pend_flags;
      rsp_err   <= pend_err;
      crc_err   <= pend_crc;
      if (rsp_valid && !rsp_ready) overrun <= 1'b1;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_result_rx.sv
// Self-checking bench for alu_result_rx: vector table + scoreboard,
// plus hand sequences for framing, timeout, overrun and reset cases.
module tb_alu_result_rx;

`ifdef ALU_RX_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        sin;
  logic        rsp_ready;
  logic        rsp_valid;
  logic [31:0] rsp_c;
  logic [3:0]  rsp_flags;
  logic [2:0]  rsp_err;
  logic        crc_err;
  logic        proto_err;
  logic        overrun;

  alu_result_rx dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .rsp_ready (rsp_ready),
    .rsp_valid (rsp_valid),
    .rsp_c     (rsp_c),
    .rsp_flags (rsp_flags),
    .rsp_err   (rsp_err),
    .crc_err   (crc_err),
    .proto_err (proto_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [31:0] c;
    logic [3:0]  flags;
    logic [2:0]  crc_xor;
    int          npre;
    logic [7:0]  ebyte;
    logic [2:0]  eerr;
  } vec_t;

  vec_t        tbl[8];
  logic [39:0] sb[$];
  logic [39:0] mon_act, mon_exp;
  int          total = 0;
  int          passed = 0;
  int          n_proto = 0;
  int          n_rsp = 0;

  function automatic logic [2:0] crc_ref(input logic [36:0] m);
    logic [39:0] r;
    r = {m, 3'b000};
    for (int i = 39; i >= 3; i--)
      if (r[i]) r[i-:4] = r[i-:4] ^ 4'b1011;
    return r[2:0];
  endfunction

  task automatic chk(input string name, input logic [39:0] act,
                     input logic [39:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s got %h want %h", name, act, exp);
  endtask

  task automatic send_bit(input logic b);
    sin = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    sin = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic t, input logic [7:0] b,
                            input logic stop);
    send_bit(1'b0);
    send_bit(t);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    send_bit(stop);
    sin = 1'b1;
  endtask

  task automatic send_rsp(input logic [31:0] c, input logic [3:0] f,
                          input logic [2:0] cx);
    logic [2:0] crc;
    for (int b = 3; b >= 0; b--) send_frame(1'b0, c[b*8 +: 8], 1'b1);
    crc = crc_ref({c, 1'b0, f}) ^ cx;
    send_frame(1'b1, {1'b0, f, crc}, 1'b1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain", 40'(sb.size()), 40'd0);
  endtask

  always @(negedge clk) begin
    if (proto_err) n_proto++;
    if (!rst && rsp_valid && rsp_ready) begin
      n_rsp++;
      mon_act = {rsp_c, rsp_flags, rsp_err, crc_err};
      total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_rsp got %h", mon_act);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_act === mon_exp) passed++;
        else $display("FAIL rsp_fields got %h want %h", mon_act, mon_exp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int p0, r0, hit_at;

    tbl[0] = '{1'b0, 32'h12345678, 4'h0, 3'h0, 0, 8'h00, 3'b000};
    tbl[1] = '{1'b1, 32'h0,        4'h0, 3'h0, 2, 8'hA5, 3'b010};
    tbl[2] = '{1'b0, 32'h12345678, 4'h0, 3'h0, 0, 8'h00, 3'b000};
    tbl[3] = '{1'b0, 32'hDEADBEEF, 4'hA, 3'h1, 0, 8'h00, 3'b000};
    tbl[4] = '{1'b1, 32'h0,        4'h0, 3'h0, 0, 8'hC9, 3'b100};
    tbl[5] = '{1'b1, 32'h0,        4'h0, 3'h0, 4, 8'h93, 3'b001};
    tbl[6] = '{1'b0, 32'h00000000, 4'h2, 3'h0, 0, 8'h00, 3'b000};
    tbl[7] = '{1'b0, 32'hFFFFFFFF, 4'hD, 3'h4, 0, 8'h00, 3'b000};

    rst = 1'b1;
    sin = 1'b1;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 40'(rsp_valid), 40'd0);
    chk("rst_c", 40'(rsp_c), 40'd0);
    chk("rst_flags", 40'(rsp_flags), 40'd0);
    chk("rst_err", 40'(rsp_err), 40'd0);
    chk("rst_crc", 40'(crc_err), 40'd0);
    chk("rst_proto", 40'(proto_err), 40'd0);
    chk("rst_overrun", 40'(overrun), 40'd0);
    rst = 1'b0;
    idle(3);

    p0 = n_proto;
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].is_err) begin
        for (int k = 0; k < tbl[i].npre; k++)
          send_frame(1'b0, 8'h5A + k[7:0], 1'b1);
        sb.push_back({32'h0, 4'h0, tbl[i].eerr, 1'b0});
        send_frame(1'b1, tbl[i].ebyte, 1'b1);
      end else begin
        sb.push_back({tbl[i].c, tbl[i].flags, 3'b000,
                      CRC_EN && (tbl[i].crc_xor != 3'b000)});
        send_rsp(tbl[i].c, tbl[i].flags, tbl[i].crc_xor);
      end
      idle(2);
      drain();
    end
    chk("table_no_proto", 40'(n_proto - p0), 40'd0);

    // bad stop bit in third DATA frame
    p0 = n_proto;
    r0 = n_rsp;
    send_frame(1'b0, 8'h11, 1'b1);
    send_frame(1'b0, 8'h22, 1'b1);
    send_frame(1'b0, 8'h33, 1'b0);
    idle(6);
    chk("stop0_proto", 40'(n_proto - p0), 40'd1);
    chk("stop0_no_rsp", 40'(n_rsp - r0), 40'd0);
    sb.push_back({32'hCAFEF00D, 4'h5, 3'b000, 1'b0});
    send_rsp(32'hCAFEF00D, 4'h5, 3'h0);
    idle(2);
    drain();

    // inter-frame timeout
    p0 = n_proto;
    send_frame(1'b0, 8'hA1, 1'b1);
    send_frame(1'b0, 8'hA2, 1'b1);
    send_frame(1'b0, 8'hA3, 1'b1);
    hit_at = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (proto_err && hit_at == 0) hit_at = i;
    end
    chk("timeout_cycle", 40'(hit_at), 40'd64);
    chk("timeout_once", 40'(n_proto - p0), 40'd1);
    sb.push_back({32'h0BADC0DE, 4'h9, 3'b000, 1'b0});
    send_rsp(32'h0BADC0DE, 4'h9, 3'h0);
    idle(2);
    drain();

    // fifth DATA frame, then lone CMD, then unknown error byte
    p0 = n_proto;
    r0 = n_rsp;
    for (int k = 0; k < 5; k++) send_frame(1'b0, 8'h40 + k[7:0], 1'b1);
    idle(2);
    chk("overflow_proto", 40'(n_proto - p0), 40'd1);
    send_frame(1'b1, 8'h00, 1'b1);
    idle(2);
    chk("lone_cmd_proto", 40'(n_proto - p0), 40'd2);
    send_frame(1'b0, 8'h77, 1'b1);
    send_frame(1'b1, 8'hFF, 1'b1);
    idle(2);
    chk("bad_err_proto", 40'(n_proto - p0), 40'd3);
    chk("seq_no_rsp", 40'(n_rsp - r0), 40'd0);
    sb.push_back({32'h89ABCDEF, 4'h1, 3'b000, 1'b0});
    send_rsp(32'h89ABCDEF, 4'h1, 3'h0);
    idle(2);
    drain();

    // two responses while stalled
    rsp_ready = 1'b0;
    send_rsp(32'h1, 4'h0, 3'h0);
    idle(3);
    send_rsp(32'h2, 4'h0, 3'h0);
    idle(3);
    chk("ovr_valid", 40'(rsp_valid), 40'd1);
    chk("ovr_c", 40'(rsp_c), 40'h2);
    chk("ovr_flag", 40'(overrun), 40'd1);
    sb.push_back({32'h2, 4'h0, 3'b000, 1'b0});
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("ovr_drop_valid", 40'(rsp_valid), 40'd0);
    chk("ovr_popped", 40'(sb.size()), 40'd0);
    chk("ovr_sticky", 40'(overrun), 40'd1);

    // reset in the middle of a frame with the line held low
    p0 = n_proto;
    r0 = n_rsp;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (15) send_bit(1'b0);
    idle(4);
    chk("mid_rst_proto", 40'(n_proto - p0), 40'd0);
    chk("mid_rst_rsp", 40'(n_rsp - r0), 40'd0);
    chk("mid_rst_overrun", 40'(overrun), 40'd0);
    sb.push_back({32'h55AA33CC, 4'h6, 3'b000, 1'b0});
    send_rsp(32'h55AA33CC, 4'h6, 3'h0);
    idle(2);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
